// File: rtl/aes_key_expand.sv
// AES-128 on-the-fly round key generator.
// One round key per key_next, one clock of latency, no pipeline stages.

module s_box (
   input  logic [7:0] a,
   output logic [7:0] y
);

   localparam logic [2047:0] TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] idx;

   // Entry 0 sits in the most significant byte of the table.
   assign idx = 11'd2047 - {a, 3'b000};
   assign y   = TAB[idx -: 8];

endmodule

module aes_key_expand #(
   parameter int LAST_ROUND = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_load,
   input  logic [127:0] key_in,
   input  logic         key_next,
   output logic [127:0] round_key,
   output logic [3:0]   round_sel,
   output logic         key_valid,
   output logic         done
);

   localparam logic [3:0] LAST_SEL = 4'(LAST_ROUND);

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state, state_nxt;
   logic [127:0] key_nxt;
   logic [3:0]   sel_nxt;
   logic         valid_nxt;
   logic         done_nxt;

   logic [31:0]  w3, rot, sub, t;
   logic [31:0]  n0, n1, n2, n3;
   logic [7:0]   rcon;

   assign w3  = round_key[31:0];
   assign rot = {w3[23:0], w3[31:24]};

   s_box u_sb0 (.a(rot[31:24]), .y(sub[31:24]));
   s_box u_sb1 (.a(rot[23:16]), .y(sub[23:16]));
   s_box u_sb2 (.a(rot[15:8]),  .y(sub[15:8]));
   s_box u_sb3 (.a(rot[7:0]),   .y(sub[7:0]));

   always_comb begin
      rcon = 8'h00;
      case (round_sel)
         4'd0:    rcon = 8'h01;
         4'd1:    rcon = 8'h02;
         4'd2:    rcon = 8'h04;
         4'd3:    rcon = 8'h08;
         4'd4:    rcon = 8'h10;
         4'd5:    rcon = 8'h20;
         4'd6:    rcon = 8'h40;
         4'd7:    rcon = 8'h80;
         4'd8:    rcon = 8'h1b;
         4'd9:    rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign t  = sub ^ {rcon, 24'h0};
   assign n0 = round_key[127:96] ^ t;
   assign n1 = round_key[95:64]  ^ n0;
   assign n2 = round_key[63:32]  ^ n1;
   assign n3 = round_key[31:0]   ^ n2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         round_key <= '0;
         round_sel <= '0;
         key_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         round_key <= key_nxt;
         round_sel <= sel_nxt;
         key_valid <= valid_nxt;
         done      <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (key_load)
         state_nxt = RUN;
      else if (state == RUN && key_next && round_sel == LAST_SEL)
         state_nxt = IDLE;
   end

   // Outputs are registered; this computes their next values.
   always_comb begin
      key_nxt   = round_key;
      sel_nxt   = round_sel;
      valid_nxt = key_valid;
      done_nxt  = 1'b0;
      if (key_load) begin
         key_nxt   = key_in;
         sel_nxt   = 4'd0;
         valid_nxt = 1'b1;
      end else if (state == RUN && key_next) begin
         if (round_sel == LAST_SEL) begin
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
         end else begin
            key_nxt = {n0, n1, n2, n3};
            sel_nxt = round_sel + 4'd1;
         end
      end
   end

endmodule
